// File: rtl/mul_pkg.sv
// Shared types and widths for the shared multiplier arbiter.
// FSM encoding plus operand/product widths.
package mul_pkg;

  localparam int OPW = 16;
  localparam int PRW = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/array_multiplier.sv
// Combinational unsigned 16x16 array multiplier.
// The caller allows it LAT cycles to settle.
module array_multiplier
  import mul_pkg::*;
(
  input  logic [OPW-1:0] i_a,
  input  logic [OPW-1:0] i_b,
  output logic [PRW-1:0] o_p
);

  always_comb begin
    o_p = '0;
    for (int i = 0; i < OPW; i++) begin
      if (i_b[i]) begin
        o_p = o_p + ({{(PRW-OPW){1'b0}}, i_a} << i);
      end
    end
  end

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one multiplier among NUM_REQ requesters.
// Define MUL_SHARE_ARB_PERF_EN to build the perf_ops completion counter.
module mul_share_arbiter
  import mul_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LAT     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [OPW*NUM_REQ-1:0]     req_a,
  input  logic [OPW*NUM_REQ-1:0]     req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic [PRW-1:0]             rsp_prod,
  output logic                       busy,
  output logic [31:0]                perf_ops
);

  localparam int IDW = $clog2(NUM_REQ);

  state_t         r_state;
  state_t         w_next;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [IDW-1:0] w_win;
  logic           w_any;
  logic [OPW-1:0] r_a;
  logic [OPW-1:0] r_b;
  logic [3:0]     r_cnt;
  logic [PRW-1:0] r_prod;
  logic [PRW-1:0] w_prod;
  logic           w_acc;
  logic           w_calc_end;
  logic           w_hs;

  // Scan downward so the lowest offset from r_ptr wins.
  always_comb begin
    int idx;
    w_any = 1'b0;
    w_win = '0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(r_ptr) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        w_any = 1'b1;
        w_win = IDW'(idx);
      end
    end
  end

  assign w_acc      = (r_state == ST_IDLE) && w_any;
  assign w_calc_end = (r_state == ST_CALC) &&
                      (r_cnt == 4'(LAT - 1));
  assign w_hs       = (r_state == ST_DONE) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_acc)      w_next = ST_CALC;
      ST_CALC: if (w_calc_end) w_next = ST_DONE;
      ST_DONE: if (w_hs)       w_next = ST_IDLE;
      default:                 w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (w_acc) req_ready = NUM_REQ'(1) << w_win;
    busy      = (r_state != ST_IDLE);
    rsp_valid = (r_state == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr  <= '0;
      r_id   <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_prod <= '0;
    end else begin
      if (w_acc) begin
        r_a   <= req_a[int'(w_win)*OPW +: OPW];
        r_b   <= req_b[int'(w_win)*OPW +: OPW];
        r_id  <= w_win;
        r_ptr <= (w_win == IDW'(NUM_REQ - 1)) ?
                 '0 : w_win + 1'b1;
      end
      if (r_state == ST_CALC) begin
        if (w_calc_end) begin
          r_cnt  <= '0;
          r_prod <= w_prod;
        end else begin
          r_cnt <= r_cnt + 4'd1;
        end
      end
    end
  end

  array_multiplier u_mul (
    .i_a (r_a),
    .i_b (r_b),
    .o_p (w_prod)
  );

  assign rsp_id   = r_id;
  assign rsp_prod = r_prod;

`ifdef MUL_SHARE_ARB_PERF_EN
  logic [31:0] r_ops;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_ops <= '0;
    else if (w_hs) r_ops <= r_ops + 32'd1;
  end
  assign perf_ops = r_ops;
`else
  assign perf_ops = '0;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter.
// Expected perf_ops follows MUL_SHARE_ARB_PERF_EN.
module tb_mul_share_arbiter;

  localparam int N = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_a = '0;
  logic [16*N-1:0] req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_id;
  logic [31:0]   rsp_prod;
  logic          busy;
  logic [31:0]   perf_ops;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mul_share_arbiter #(.NUM_REQ(N), .LAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .busy      (busy),
    .perf_ops  (perf_ops)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic wait_ready(output int c, output logic [N-1:0] rr);
    c  = -1;
    rr = '0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        c  = cyc;
        rr = req_ready;
        return;
      end
    end
    chk("ready_timeout", 32'd1, 32'd0);
  endtask

  task automatic wait_rsp(output int c);
    c = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        c = cyc;
        return;
      end
    end
    chk("rsp_timeout", 32'd1, 32'd0);
  endtask

  task automatic drop_valid();
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  int t0, t1, prev, seen;
  logic [N-1:0] rr;
  int order [5] = '{0, 1, 2, 3, 0};

  initial begin
    do_reset();
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_prod", rsp_prod, 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_perf", perf_ops, 32'd0);

    // Max operands, single requester, latency
    req_a[15:0] = 16'hFFFF;
    req_b[15:0] = 16'hFFFF;
    rsp_ready   = 1'b1;
    req_valid   = 4'b0001;
    wait_ready(t0, rr);
    chk("max_grant", 32'(rr), 32'h1);
    drop_valid();
    wait_rsp(t1);
    chk("max_latency", 32'(t1 - t0), 32'd3);
    chk("max_prod", rsp_prod, 32'hFFFE0001);
    chk("max_id", 32'(rsp_id), 32'd0);

    // Round robin over all four
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_a[16*i +: 16] = 16'(i + 1);
      req_b[16*i +: 16] = 16'h0100;
    end
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    prev = 0;
    for (int k = 0; k < 5; k++) begin
      wait_ready(t0, rr);
      chk($sformatf("rr_grant%0d", k), 32'(rr),
          32'(1) << order[k]);
      if (k > 0) chk($sformatf("rr_gap%0d", k),
                     32'(t0 - prev), 32'd4);
      prev = t0;
    end
    drop_valid();
    wait_rsp(t1);
    chk("rr_last_id", 32'(rsp_id), 32'd0);
    chk("rr_last_prod", rsp_prod, 32'h00000100);

    // Backpressure in DONE
    do_reset();
    req_a[47:32] = 16'h0003;
    req_b[47:32] = 16'h0005;
    req_valid    = 4'b0100;
    wait_ready(t0, rr);
    chk("bp_grant", 32'(rr), 32'h4);
    wait_rsp(t1);
    chk("bp_prod0", rsp_prod, 32'd15);
    chk("bp_id0", 32'(rsp_id), 32'd2);
    for (int k = 1; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp_valid%0d", k), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp_prod%0d", k), rsp_prod, 32'd15);
      chk($sformatf("bp_id%0d", k), 32'(rsp_id), 32'd2);
      chk($sformatf("bp_ready%0d", k), 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_hs_valid", 32'(rsp_valid), 32'd1);
    chk("bp_hs_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_grant", 32'(req_ready), 32'h4);
    drop_valid();
    wait_rsp(t1);

    // Reset during CALC aborts
    do_reset();
    req_a[31:16] = 16'h0007;
    req_b[31:16] = 16'h0009;
    rsp_ready    = 1'b1;
    req_valid    = 4'b0010;
    wait_ready(t0, rr);
    chk("ab_grant", 32'(rr), 32'h2);
    drop_valid();
    chk("ab_busy_pre", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("ab_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("ab_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    chk("ab_no_rsp", 32'(seen), 32'd0);
    @(posedge clk);
    #1 req_valid = 4'b1111;
    wait_ready(t0, rr);
    chk("ab_next_grant", 32'(rr), 32'h1);
    drop_valid();
    wait_rsp(t1);

    // Zero and shifted operands, perf count
    do_reset();
    req_a[15:0]  = 16'h0000;
    req_b[15:0]  = 16'h1234;
    req_a[63:48] = 16'h8000;
    req_b[63:48] = 16'h0002;
    rsp_ready    = 1'b1;
    req_valid    = 4'b0001;
    wait_ready(t0, rr);
    drop_valid();
    wait_rsp(t1);
    chk("zero_prod", rsp_prod, 32'h00000000);
    @(posedge clk);
    #1 req_valid = 4'b1000;
    wait_ready(t0, rr);
    chk("sh_grant", 32'(rr), 32'h8);
    drop_valid();
    wait_rsp(t1);
    chk("sh_prod", rsp_prod, 32'h00010000);
    chk("sh_id", 32'(rsp_id), 32'd3);
    @(negedge clk);
`ifdef MUL_SHARE_ARB_PERF_EN
    chk("perf_ops", perf_ops, 32'd2);
`else
    chk("perf_ops", perf_ops, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, giving the number of requesters sharing one 16x16 multiplier; legal range 2..8.
REQ-002 SHALL have parameter LAT, default 2, giving the settle cycles allowed for the multiplier; legal range 1..15.
REQ-003 SHALL define IDW = clog2(NUM_REQ) as a localparam.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits: bit i set means requester i has an operand pair pending.
REQ-007 SHALL have port req_ready, output, NUM_REQ bits: one-hot accept strobe.
REQ-008 SHALL have port req_a, input, 16*NUM_REQ bits: requester i's multiplicand in bits [16i+15:16i].
REQ-009 SHALL have port req_b, input, 16*NUM_REQ bits: requester i's multiplier, same packing as req_a.
REQ-010 SHALL have port rsp_valid, output, 1 bit: a result is presented.
REQ-011 SHALL have port rsp_ready, input, 1 bit: the consumer accepts the result.
REQ-012 SHALL have port rsp_id, output, IDW bits: index of the requester that owns the result.
REQ-013 SHALL have port rsp_prod, output, 32 bits: unsigned product.
REQ-014 SHALL have port busy, output, 1 bit: high when the FSM state is not IDLE.
REQ-015 SHALL have port perf_ops, output, 32 bits: count of completed operations.

Function
REQ-016 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-017 In IDLE with any req_valid set, SHALL grant round-robin starting from index ptr, assert req_ready for the winner only in that cycle, latch its operands and id, and go to CALC.
REQ-018 In IDLE, SHALL set ptr to (winner+1) mod NUM_REQ on each accept; ptr SHALL NOT change otherwise.
REQ-019 req_ready SHALL be zero in every cycle outside IDLE and in IDLE when no req_valid bit is set.
REQ-020 In CALC, SHALL feed the latched operands to the multiplier, count LAT cycles, then register the product into rsp_prod and enter DONE.
REQ-021 Timing: accept in cycle T SHALL give rsp_valid=1 from cycle T+LAT+1.
REQ-022 In DONE, SHALL hold rsp_valid, rsp_id and rsp_prod stable until rsp_valid&rsp_ready, then return to IDLE.
REQ-023 SHALL NOT bypass: a new accept SHALL occur no earlier than the cycle after the response handshake, so the minimum spacing between accepts is LAT+2 cycles.
REQ-024 A requester dropping req_valid before being granted SHALL be legal and SHALL leave no residual state.
REQ-025 perf_ops SHALL increment by 1 on each response handshake and wrap from 0xFFFFFFFF to 0.
REQ-026 rsp_prod SHALL equal a*b, computed as a zero-extended unsigned product, for all operand pairs.

Reset
REQ-027 On rst SHALL immediately force: state IDLE, ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_prod 0, busy 0, perf_ops 0, LAT counter 0.
REQ-028 Reset asserted during CALC or DONE SHALL abort the operation, and no response for it SHALL ever appear.

Configuration
REQ-029 With macro MUL_SHARE_ARB_PERF_EN defined, SHALL implement the perf_ops counter per REQ-025.
REQ-030 Without MUL_SHARE_ARB_PERF_EN, perf_ops SHALL be constant 0, no counter flops SHALL be present, and the port SHALL remain.

Structure
REQ-031 SHALL place the FSM state enum, the operand width (16) and the product width (32) in shared package mul_pkg.
REQ-032 SHALL instantiate exactly one array_multiplier as its datapath sub-module.
REQ-033 Arbitration SHALL be inline logic, with no separate arbiter module.

Verification
REQ-034 Bench SHALL check: after reset, req 0 only with A=0xFFFF, B=0xFFFF and LAT=2 -> rsp_valid at T+3, rsp_prod=0xFFFE0001, rsp_id=0.
REQ-035 Bench SHALL check: all four req_valid held high after reset with rsp_ready=1 -> grant order 0,1,2,3,0 with accepts spaced 4 cycles apart.
REQ-036 Bench SHALL check: rsp_ready held low for 5 cycles in DONE -> rsp_* stable throughout, req_ready=0, and the handshake on the 6th cycle returns the FSM to IDLE.
REQ-037 Bench SHALL check: rst pulsed during CALC -> rsp_valid=0 and busy=0 immediately, and the next grant goes to requester 0.
REQ-038 Bench SHALL check: A=0x0000, B=0x1234 then A=0x8000, B=0x0002 -> products 0x00000000 and 0x00010000, with perf_ops=2 when MUL_SHARE_ARB_PERF_EN is defined and 0 when it is not.
